// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with valid/ready flow control, flush and an
// optional skid entry. Holds up to two in-order beats when SKID is set,
// otherwise a single entry whose ready passes straight through.
module id_ex_stage_reg #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned RADDR_W = 5,
   parameter int unsigned WB_W    = 2,
   parameter int unsigned M_W     = 3,
   parameter int unsigned SKID    = 1,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WB_W-1:0]    ctl_wb,
   input  logic [M_W-1:0]     ctl_m,
   input  logic [3:0]         ctl_ex,
   input  logic [XLEN-1:0]    npc,
   input  logic [XLEN-1:0]    rdata1,
   input  logic [XLEN-1:0]    rdata2,
   input  logic [XLEN-1:0]    imm,
   input  logic [RADDR_W-1:0] rt_in,
   input  logic [RADDR_W-1:0] rd_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WB_W-1:0]    wb_ctl,
   output logic [M_W-1:0]     m_ctl,
   output logic               regdst,
   output logic [1:0]         aluop,
   output logic               alusrc,
   output logic [XLEN-1:0]    npc_out,
   output logic [XLEN-1:0]    rdata1_out,
   output logic [XLEN-1:0]    rdata2_out,
   output logic [XLEN-1:0]    imm_out,
   output logic [RADDR_W-1:0] rt_out,
   output logic [RADDR_W-1:0] rd_out,
   output logic [CNT_W-1:0]   stall_cnt
);

   // Whole beat is moved as one vector so fields can never mix between entries.
   localparam int unsigned BW = WB_W + M_W + 4 + 4 * XLEN + 2 * RADDR_W;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [BW-1:0]    main_q, main_d;
   logic [BW-1:0]    skid_q, skid_d;
   logic [BW-1:0]    in_beat;
   logic             in_ready_q;
   logic             rdy_q;
   logic [CNT_W-1:0] stall_q;
   logic             accept, retire;

   logic [WB_W-1:0]  wb_raw;
   logic [M_W-1:0]   m_raw;
   logic [3:0]       ex_raw;

   assign in_beat   = {ctl_wb, ctl_m, ctl_ex, npc, rdata1, rdata2, imm, rt_in, rd_in};
   assign out_valid = (state_q != ST_EMPTY);

   // rdy_q keeps the pass-through ready low until the first edge after reset.
   assign in_ready  = (SKID != 0) ? in_ready_q : (rdy_q && (!out_valid || out_ready));

   assign accept = in_valid && in_ready;
   assign retire = out_valid && out_ready;

   assign {wb_raw, m_raw, ex_raw, npc_out, rdata1_out, rdata2_out, imm_out, rt_out, rd_out} =
      main_q;

   // Control is forced to zero on bubbles; data keeps the last head beat.
   assign wb_ctl    = out_valid ? wb_raw    : '0;
   assign m_ctl     = out_valid ? m_raw     : '0;
   assign regdst    = out_valid ? ex_raw[3] : 1'b0;
   assign aluop     = out_valid ? ex_raw[2:1] : 2'b00;
   assign alusrc    = out_valid ? ex_raw[0] : 1'b0;
   assign stall_cnt = stall_q;

   // Entry occupancy and data movement; flush drops everything incl. the incoming beat.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  main_d  = in_beat;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && retire) begin
                  main_d = in_beat;
               end else if (accept) begin
                  skid_d  = in_beat;
                  state_d = ST_FULL;
               end else if (retire) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (retire) begin
                  main_d  = skid_q;
                  state_d = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // State, entries and registered ready.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= (state_d != ST_FULL);
         rdy_q      <= 1'b1;
      end
   end

   // Saturating count of cycles where execute is holding off a valid beat.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
      end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
         stall_q <= stall_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: three instances (skid, skid with 3-bit counter,
// no skid) share stimulus and are compared against queue-based models.
module tb_id_ex_stage_reg;

   typedef struct packed {
      logic [1:0]  wb;
      logic [2:0]  m;
      logic [3:0]  ex;
      logic [31:0] npc;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [31:0] imm;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } beat_t;

   typedef struct {
      logic        iv;
      logic [31:0] npc;
      logic        ordy;
      logic        fl;
      logic        eov;
      logic        eir;
      logic [31:0] enpc;
   } vec_t;

   logic clock, reset, flush, in_valid, out_ready;
   beat_t cur;

   logic a_ir, a_ov, a_rdst, a_asrc; logic [1:0] a_wb, a_aop; logic [2:0] a_m;
   logic [31:0] a_npc, a_r1, a_r2, a_imm; logic [4:0] a_rt, a_rd; logic [15:0] a_st;
   logic s_ir, s_ov, s_rdst, s_asrc; logic [1:0] s_wb, s_aop; logic [2:0] s_m;
   logic [31:0] s_npc, s_r1, s_r2, s_imm; logic [4:0] s_rt, s_rd; logic [2:0] s_st;
   logic n_ir, n_ov, n_rdst, n_asrc; logic [1:0] n_wb, n_aop; logic [2:0] n_m;
   logic [31:0] n_npc, n_r1, n_r2, n_imm; logic [4:0] n_rt, n_rd; logic [15:0] n_st;

   int checks = 0;
   int errors = 0;

   // Reference model state: queues of held beats, last shown head, stall tallies.
   beat_t qa[$];
   beat_t qb[$];
   beat_t shown_a, shown_b;
   logic  rdy_a, started_b;
   int    stall_a, stall_b;

   id_ex_stage_reg u_main (
      .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_ir),
      .ctl_wb(cur.wb), .ctl_m(cur.m), .ctl_ex(cur.ex), .npc(cur.npc), .rdata1(cur.r1),
      .rdata2(cur.r2), .imm(cur.imm), .rt_in(cur.rt), .rd_in(cur.rd), .out_valid(a_ov),
      .out_ready(out_ready), .wb_ctl(a_wb), .m_ctl(a_m), .regdst(a_rdst), .aluop(a_aop),
      .alusrc(a_asrc), .npc_out(a_npc), .rdata1_out(a_r1), .rdata2_out(a_r2),
      .imm_out(a_imm), .rt_out(a_rt), .rd_out(a_rd), .stall_cnt(a_st)
   );

   id_ex_stage_reg #(.CNT_W(3)) u_sat (
      .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_ir),
      .ctl_wb(cur.wb), .ctl_m(cur.m), .ctl_ex(cur.ex), .npc(cur.npc), .rdata1(cur.r1),
      .rdata2(cur.r2), .imm(cur.imm), .rt_in(cur.rt), .rd_in(cur.rd), .out_valid(s_ov),
      .out_ready(out_ready), .wb_ctl(s_wb), .m_ctl(s_m), .regdst(s_rdst), .aluop(s_aop),
      .alusrc(s_asrc), .npc_out(s_npc), .rdata1_out(s_r1), .rdata2_out(s_r2),
      .imm_out(s_imm), .rt_out(s_rt), .rd_out(s_rd), .stall_cnt(s_st)
   );

   id_ex_stage_reg #(.SKID(0)) u_ns (
      .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(n_ir),
      .ctl_wb(cur.wb), .ctl_m(cur.m), .ctl_ex(cur.ex), .npc(cur.npc), .rdata1(cur.r1),
      .rdata2(cur.r2), .imm(cur.imm), .rt_in(cur.rt), .rd_in(cur.rd), .out_valid(n_ov),
      .out_ready(out_ready), .wb_ctl(n_wb), .m_ctl(n_m), .regdst(n_rdst), .aluop(n_aop),
      .alusrc(n_asrc), .npc_out(n_npc), .rdata1_out(n_r1), .rdata2_out(n_r2),
      .imm_out(n_imm), .rt_out(n_rt), .rd_out(n_rd), .stall_cnt(n_st)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [146:0] act, input logic [146:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      qa.delete();
      qb.delete();
      shown_a   = '0;
      shown_b   = '0;
      rdy_a     = 1'b0;
      started_b = 1'b0;
      stall_a   = 0;
      stall_b   = 0;
   endtask

   // Advance both models by one clock edge using the inputs currently applied.
   task automatic model_step();
      logic acc, ov;
      ov  = (qa.size() != 0);
      acc = in_valid && rdy_a;
      if (ov && !out_ready) stall_a++;
      if (flush) qa.delete();
      else begin
         if (ov && out_ready) void'(qa.pop_front());
         if (acc) qa.push_back(cur);
      end
      rdy_a = (qa.size() < 2);
      if (qa.size() != 0) shown_a = qa[0];

      ov  = (qb.size() != 0);
      acc = in_valid && started_b && (!ov || out_ready);
      if (ov && !out_ready) stall_b++;
      if (flush) qb.delete();
      else begin
         if (ov && out_ready) void'(qb.pop_front());
         if (acc) qb.push_back(cur);
      end
      started_b = 1'b1;
      if (qb.size() != 0) shown_b = qb[0];
   endtask

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic check_all();
      beat_t ea, eb;
      logic  ova, ovb, irb;
      ova = (qa.size() != 0);
      ovb = (qb.size() != 0);
      irb = started_b && (!ovb || out_ready);
      ea = shown_a;
      eb = shown_b;
      if (!ova) begin ea.wb = '0; ea.m = '0; ea.ex = '0; end
      if (!ovb) begin eb.wb = '0; eb.m = '0; eb.ex = '0; end
      chk("main out_valid", 147'(a_ov), 147'(ova));
      chk("main in_ready", 147'(a_ir), 147'(rdy_a));
      chk("main beat", {a_wb, a_m, a_rdst, a_aop, a_asrc, a_npc, a_r1, a_r2, a_imm, a_rt, a_rd},
          ea);
      chk("main stall_cnt", 147'(a_st), 147'(sat(stall_a, 65535)));
      chk("sat out_valid", 147'(s_ov), 147'(ova));
      chk("sat in_ready", 147'(s_ir), 147'(rdy_a));
      chk("sat beat", {s_wb, s_m, s_rdst, s_aop, s_asrc, s_npc, s_r1, s_r2, s_imm, s_rt, s_rd},
          ea);
      chk("sat stall_cnt", 147'(s_st), 147'(sat(stall_a, 7)));
      chk("noskid out_valid", 147'(n_ov), 147'(ovb));
      chk("noskid in_ready", 147'(n_ir), 147'(irb));
      chk("noskid beat", {n_wb, n_m, n_rdst, n_aop, n_asrc, n_npc, n_r1, n_r2, n_imm, n_rt,
          n_rd}, eb);
      chk("noskid stall_cnt", 147'(n_st), 147'(sat(stall_b, 65535)));
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
      cur       = '0;
   endtask

   // Synchronous-looking reset pulse from a negedge; returns after first edge post-release.
   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      model_reset();
      #1 check_all();
      @(negedge clock);
      reset = 1'b0;
      #1 check_all();
      tick();
   endtask

   function automatic beat_t tbl_beat(input logic [31:0] n);
      beat_t b;
      b = '{wb: 2'b11, m: 3'b101, ex: 4'b1011, npc: n, r1: n + 1, r2: n + 2, imm: n + 3,
            rt: 5'd1, rd: 5'd2};
      return b;
   endfunction

   vec_t tbl[14];
   logic [159:0] rnd;

   initial begin
      //            iv  npc     ordy fl   eov  eir  enpc
      tbl[0]  = '{1'b1, 32'h04, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00};
      tbl[1]  = '{1'b1, 32'h08, 1'b1, 1'b0, 1'b1, 1'b1, 32'h04};
      tbl[2]  = '{1'b1, 32'h0C, 1'b1, 1'b0, 1'b1, 1'b1, 32'h08};
      tbl[3]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0C};
      tbl[4]  = '{1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0C};
      tbl[5]  = '{1'b1, 32'h14, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10};
      tbl[6]  = '{1'b1, 32'h18, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10};
      tbl[7]  = '{1'b1, 32'h18, 1'b1, 1'b0, 1'b1, 1'b0, 32'h10};
      tbl[8]  = '{1'b1, 32'h18, 1'b1, 1'b0, 1'b1, 1'b1, 32'h14};
      tbl[9]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h18};
      tbl[10] = '{1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 32'h18};
      tbl[11] = '{1'b1, 32'h24, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20};
      tbl[12] = '{1'b1, 32'h28, 1'b0, 1'b1, 1'b1, 1'b0, 32'h20};
      tbl[13] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20};

      idle_inputs();
      reset = 1'b1;
      model_reset();
      repeat (2) @(negedge clock);
      #1 check_all();
      chk("reset out_valid", 147'(a_ov), 147'(0));
      chk("reset in_ready", 147'(a_ir), 147'(0));
      @(negedge clock);
      reset = 1'b0;
      #1 check_all();
      tick();
      check_all();
      chk("post-reset in_ready", 147'(a_ir), 147'(1));
      chk("post-reset stall_cnt", 147'(a_st), 147'(0));

      // Back-to-back, backpressure to FULL, then flush of a FULL register.
      for (int i = 0; i < 14; i++) begin
         in_valid  = tbl[i].iv;
         out_ready = tbl[i].ordy;
         flush     = tbl[i].fl;
         cur       = tbl_beat(tbl[i].npc);
         #1 check_all();
         chk($sformatf("tbl[%0d] out_valid", i), 147'(a_ov), 147'(tbl[i].eov));
         chk($sformatf("tbl[%0d] in_ready", i), 147'(a_ir), 147'(tbl[i].eir));
         chk($sformatf("tbl[%0d] npc_out", i), 147'(a_npc), 147'(tbl[i].enpc));
         if (!tbl[i].eov)
            chk($sformatf("tbl[%0d] ctl zero", i), 147'({a_wb, a_m, a_rdst, a_aop, a_asrc}),
                147'(0));
         tick();
      end

      // Stall counter: 5 cycles, then saturation of the 3-bit instance.
      do_reset();
      in_valid = 1'b1;
      cur      = tbl_beat(32'h40);
      #1 check_all();
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1 check_all();
         tick();
      end
      chk("stall 5 main", 147'(a_st), 147'(5));
      chk("stall 5 sat", 147'(s_st), 147'(5));
      for (int i = 0; i < 5; i++) begin
         #1 check_all();
         tick();
      end
      chk("stall 10 main", 147'(a_st), 147'(10));
      chk("stall sat at 7", 147'(s_st), 147'(7));

      // No-skid ready follows out_ready combinationally while holding a beat.
      #1 chk("noskid ir held", 147'(n_ir), 147'(0));
      out_ready = 1'b1;
      #1 chk("noskid ir follows", 147'(n_ir), 147'(1));
      check_all();
      tick();

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         rnd       = {$urandom, $urandom, $urandom, $urandom, $urandom};
         cur       = rnd[146:0];
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         flush     = ($urandom_range(19) == 0);
         #1 check_all();
         tick();
      end

      // Reset mid-stream: outputs must clear without a clock edge.
      in_valid  = 1'b1;
      out_ready = 1'b0;
      flush     = 1'b0;
      cur       = tbl_beat(32'h80);
      #1 check_all();
      tick();
      cur = tbl_beat(32'h84);
      #1 check_all();
      chk("pre-reset valid", 147'(a_ov), 147'(1));
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      chk("async reset out_valid", 147'(a_ov), 147'(0));
      chk("async reset npc_out", 147'(a_npc), 147'(0));
      chk("async reset noskid", 147'({n_ov, n_ir, n_npc}), 147'(0));
      @(negedge clock);
      idle_inputs();
      reset = 1'b0;
      #1 check_all();
      tick();
      check_all();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
